// File: rtl/hline_pkg.sv
// Shared constants and types for the horizontal gated obstacle bar.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes).
//
// Raster totals, bar x-extent, gap travel limits and the bounce FSM
// state encoding used by hline_gate and hline_motion_fsm.
package hline_pkg;

  // 640x480@60 timing: 800 pixel clocks per line, 525 lines per frame.
  localparam logic [9:0]  H_TOTAL    = 10'd800;
  localparam logic [9:0]  V_TOTAL    = 10'd525;

  // Bar spans X_LEFT < px < X_RIGHT, minus the gap.
  localparam logic [15:0] X_LEFT     = 16'd9;
  localparam logic [15:0] X_RIGHT    = 16'd631;
  localparam logic [15:0] GAP_MARGIN = 16'd16;

  // Gap travel limits; GAP_MIN >= GAP_MARGIN keeps gap_x-16 from wrapping.
  localparam logic [15:0] GAP_MIN    = 16'd32;
  localparam logic [15:0] GAP_MAX    = 16'd600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } motion_state_t;

  // Gap length in pixels from the 3-bit switch field: {sel, 5'b0}.
  function automatic logic [15:0] gap_len(input logic [2:0] sel);
    return {8'd0, sel, 5'd0};
  endfunction

endpackage

// File: rtl/hline_motion_fsm.sv
// Bounce FSM and gap-position counter for the horizontal obstacle bar.
// Latency: gap_x/dir_right update one cycle after the frame strobe.
// Backpressure: none; acts only on the frame strobe, stop=0 freezes the gap.
//
// Ports:
//   clk, reset_n     pixel clock, asynchronous active-low reset
//   frame            one-cycle per-frame strobe; all updates gated by it
//   start_machine    IDLE -> RIGHT (ignored in other states)
//   load_counter     reload gap to START_X, state untouched (highest priority)
//   stop             1 = running, 0 = gap holds
//   gap_x            current left gap coordinate
//   dir_right        1 while in RIGHT
module hline_motion_fsm
  import hline_pkg::*;
#(
  parameter logic [15:0] START_X = 16'd320
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame,
  input  logic        start_machine,
  input  logic        load_counter,
  input  logic        stop,
  output logic [15:0] gap_x,
  output logic        dir_right
);

  motion_state_t state_q, state_d;
  logic [15:0]   gap_q, gap_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gap_q   <= START_X;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (frame) begin
      if (load_counter) begin
        // A reload repositions the gap but keeps the current direction.
        gap_d = START_X;
      end else begin
        case (state_q)
          IDLE:    if (start_machine)    state_d = RIGHT;
          RIGHT:   if (gap_q == GAP_MAX) state_d = LEFT;
          LEFT:    if (gap_q == GAP_MIN) state_d = RIGHT;
          default:                       state_d = IDLE;
        endcase
        // At a limit neither branch fires: the gap holds for the strobe on
        // which the direction flips, and moves away on the following one.
        if (stop) begin
          if (state_q == RIGHT && gap_q < GAP_MAX) begin
            gap_d = gap_q + 16'd1;
          end else if (state_q == LEFT && gap_q > GAP_MIN) begin
            gap_d = gap_q - 16'd1;
          end
        end
      end
    end
  end

  assign gap_x     = gap_q;
  assign dir_right = (state_q == RIGHT);

endmodule

// File: rtl/hline_gate.sv
// Horizontal obstacle bar with a sliding gap for the VGA playfield.
// Latency: h_line/sha are registered, one cycle behind the internal raster.
// Backpressure: none; free-running raster, motion advances only on frame.
//
// Ports:
//   clk, reset_n     25 MHz pixel clock, asynchronous active-low reset
//   frame            per-frame strobe (pulsed in vertical blank)
//   start_machine    start gap motion (sampled on frame)
//   load_counter     reload gap to START_X (sampled on frame)
//   flash            blink phase applied to the frozen bar
//   stop             1 = running/solid, 0 = frozen/blinking
//   sw[6:4]          gap length = {sw, 5'b0}
//   h_line           visible bar pixel (blink gated)
//   sha              ungated bar pixel for shadow/collision
//   gap_x            current left gap coordinate
//   dir_right        1 while moving right
//
// Build option: define HLINE_FLASH_EN to blink the bar while frozen
// (h_line = sha & (stop | flash)); otherwise h_line = sha and flash is unused.
module hline_gate
  import hline_pkg::*;
#(
  parameter logic [15:0] BAR_Y0  = 16'd232,
  parameter logic [15:0] BAR_Y1  = 16'd240,
  parameter logic [15:0] START_X = 16'd320
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame,
  input  logic        start_machine,
  input  logic        load_counter,
  input  logic        flash,
  input  logic        stop,
  input  logic [6:4]  sw,
  output logic        h_line,
  output logic        sha,
  output logic [15:0] gap_x,
  output logic        dir_right
);

  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        sha_q, sha_d;
  logic        h_line_q, h_line_d;

  logic [15:0] px16, py16;
  logic [15:0] gap_lo, gap_hi;
  logic        in_rows, left_seg, right_seg;

  hline_motion_fsm #(
    .START_X (START_X)
  ) u_motion (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame         (frame),
    .start_machine (start_machine),
    .load_counter  (load_counter),
    .stop          (stop),
    .gap_x         (gap_x),
    .dir_right     (dir_right)
  );

  // Free-running raster; py advances on each px wrap.
  always_comb begin
    px_d = px_q + 10'd1;
    py_d = py_q;
    if (px_q == H_TOTAL - 10'd1) begin
      px_d = 10'd0;
      py_d = (py_q == V_TOTAL - 10'd1) ? 10'd0 : py_q + 10'd1;
    end
  end

  // Geometry: the gap occupies (gap_x-16, gap_x+len); the 16-px margin on the
  // left is part of the opening, so the left segment stops at gap_x-16.
  always_comb begin
    px16      = {6'd0, px_q};
    py16      = {6'd0, py_q};
    gap_lo    = gap_x - GAP_MARGIN;
    gap_hi    = gap_x + gap_len(sw);
    in_rows   = (py16 >= BAR_Y0) && (py16 <= BAR_Y1);
    left_seg  = in_rows && (px16 > X_LEFT) && (px16 <= gap_lo);
    right_seg = in_rows && (px16 >= gap_hi) && (px16 < X_RIGHT);
    sha_d     = left_seg | right_seg;
  end

`ifdef HLINE_FLASH_EN
  assign h_line_d = sha_d & (stop | flash);
`else
  logic unused_flash;
  assign unused_flash = flash;
  assign h_line_d     = sha_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q     <= 10'd0;
      py_q     <= 10'd0;
      sha_q    <= 1'b0;
      h_line_q <= 1'b0;
    end else begin
      px_q     <= px_d;
      py_q     <= py_d;
      sha_q    <= sha_d;
      h_line_q <= h_line_d;
    end
  end

  assign sha    = sha_q;
  assign h_line = h_line_q;

endmodule

// File: tb/tb_hline_gate.sv
// Bench for hline_gate. The bar band is moved to rows 4..12 so bar rows are
// reached within a few thousand cycles of reset instead of ~186k.
module tb_hline_gate;

  localparam logic [15:0] START = 16'd320;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame = 1'b0;
  logic        start_machine = 1'b0;
  logic        load_counter = 1'b0;
  logic        flash = 1'b0;
  logic        stop = 1'b1;
  logic [6:4]  sw = 3'b010;
  logic        h_line, sha, dir_right;
  logic [15:0] gap_x;

  int vectors = 0;
  int miscompares = 0;

  hline_gate #(
    .BAR_Y0  (16'd4),
    .BAR_Y1  (16'd12),
    .START_X (START)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame         (frame),
    .start_machine (start_machine),
    .load_counter  (load_counter),
    .flash         (flash),
    .stop          (stop),
    .sw            (sw),
    .h_line        (h_line),
    .sha           (sha),
    .gap_x         (gap_x),
    .dir_right     (dir_right)
  );

  always #20 clk = ~clk;

  // Reference raster position, valid at each negedge for the coming posedge.
  int tb_px, tb_py;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_px <= 0;
      tb_py <= 0;
    end else if (tb_px == 799) begin
      tb_px <= 0;
      tb_py <= (tb_py == 524) ? 0 : tb_py + 1;
    end else begin
      tb_px <= tb_px + 1;
    end
  end

  // Scoreboards: pixel expectations and per-strobe motion expectations.
  bit          pix_q[$];
  bit          hl_q[$];
  logic [15:0] gexp_q[$];
  bit          dexp_q[$];

  // Motion reference: 0 idle, 1 right, 2 left.
  int          m_state = 0;
  logic [15:0] m_gap = START;

  task automatic model_step(input bit st, input bit ld, input bit sp);
    int ns;
    ns = m_state;
    if (ld) begin
      m_gap = START;
    end else begin
      if (m_state == 0 && st) ns = 1;
      if (m_state == 1 && m_gap == 600) ns = 2;
      if (m_state == 2 && m_gap == 32) ns = 1;
      if (sp && m_state == 1 && m_gap < 600) m_gap = m_gap + 16'd1;
      if (sp && m_state == 2 && m_gap > 32) m_gap = m_gap - 16'd1;
    end
    m_state = ns;
  endtask

  // One frame strobe starting at a negedge; pushes the expected result.
  task automatic strobe(input bit st, input bit ld, input bit sp);
    frame = 1'b1; start_machine = st; load_counter = ld; stop = sp;
    model_step(st, ld, sp);
    gexp_q.push_back(m_gap);
    dexp_q.push_back(m_state == 1);
    @(negedge clk);
    frame = 1'b0; start_machine = 1'b0; load_counter = 1'b0;
  endtask

  task automatic wait_pixel(input int row, input int col, output bit ok);
    int n;
    n = 0;
    while (!(tb_py == row && tb_px == col) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 20000);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL wait_pixel: row %0d col %0d not reached (at %0d,%0d)", row, col, tb_py, tb_px);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors += 4;
    if (sha !== 1'b0)      begin miscompares++; $display("FAIL reset_sha: got %b want 0", sha); end
    if (h_line !== 1'b0)   begin miscompares++; $display("FAIL reset_h_line: got %b want 0", h_line); end
    if (gap_x !== 16'd320) begin miscompares++; $display("FAIL reset_gap_x: got %0d want 320", gap_x); end
    if (dir_right !== 1'b0) begin miscompares++; $display("FAIL reset_dir: got %b want 0", dir_right); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Row 8 with gap 320 and length 64: bar on 10..304 and 384..630.
  task automatic test_row_scan;
    bit ok, e, got_s, got_h;
    wait_pixel(8, 0, ok);
    if (!ok) return;
    for (int i = 0; i <= 800; i++) begin
      if (pix_q.size() > 0) begin
        e = pix_q.pop_front();
        got_s = sha; got_h = h_line;
        vectors += 2;
        if (got_s !== e) begin miscompares++; $display("FAIL row_sha px=%0d: got %b want %b", i - 1, got_s, e); end
        if (got_h !== e) begin miscompares++; $display("FAIL row_h_line px=%0d: got %b want %b", i - 1, got_h, e); end
      end
      if (i < 800) pix_q.push_back((tb_px >= 10 && tb_px <= 304) || (tb_px >= 384 && tb_px <= 630));
      @(negedge clk);
    end
  endtask

  task automatic test_motion;
    logic [15:0] g; bit d;
    strobe(1'b1, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      strobe(1'b0, 1'b0, 1'b1);
      g = gexp_q.pop_front(); d = dexp_q.pop_front();
      vectors += 2;
      if (gap_x !== g)     begin miscompares++; $display("FAIL motion_gap: got %0d want %0d", gap_x, g); end
      if (dir_right !== d) begin miscompares++; $display("FAIL motion_dir: got %b want %b", dir_right, d); end
    end
    vectors += 2;
    if (gap_x !== 16'd330)  begin miscompares++; $display("FAIL motion_gap330: got %0d want 330", gap_x); end
    if (dir_right !== 1'b1) begin miscompares++; $display("FAIL motion_dir_right: got %b want 1", dir_right); end
  endtask

  // Frozen: gap at 330 holds; scan row 10 with flash toggling every pixel.
  task automatic test_freeze;
    bit ok, es, eh;
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0, 1'b0, 1'b0);
      void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
      vectors += 2;
      if (gap_x !== 16'd330)  begin miscompares++; $display("FAIL freeze_gap: got %0d want 330", gap_x); end
      if (dir_right !== 1'b1) begin miscompares++; $display("FAIL freeze_dir: got %b want 1", dir_right); end
    end
    wait_pixel(10, 0, ok);
    if (!ok) return;
    for (int i = 0; i <= 800; i++) begin
      if (pix_q.size() > 0) begin
        es = pix_q.pop_front(); eh = hl_q.pop_front();
        vectors += 2;
        if (sha !== es)    begin miscompares++; $display("FAIL freeze_sha px=%0d: got %b want %b", i - 1, sha, es); end
        if (h_line !== eh) begin miscompares++; $display("FAIL freeze_h_line px=%0d: got %b want %b", i - 1, h_line, eh); end
      end
      flash = ~flash;
      if (i < 800) begin
        es = (tb_px >= 10 && tb_px <= 314) || (tb_px >= 394 && tb_px <= 630);
        pix_q.push_back(es);
`ifdef HLINE_FLASH_EN
        hl_q.push_back(es & flash);
`else
        hl_q.push_back(es);
`endif
      end
      @(negedge clk);
    end
    flash = 1'b0;
    stop = 1'b1;
  endtask

  task automatic run_until(input logic [15:0] target, input string name);
    logic [15:0] g; bit d; int n;
    n = 0;
    while (m_gap != target && n < 2000) begin
      strobe(1'b0, 1'b0, 1'b1);
      g = gexp_q.pop_front(); d = dexp_q.pop_front();
      vectors += 2;
      if (gap_x !== g)     begin miscompares++; $display("FAIL %s_gap: got %0d want %0d", name, gap_x, g); end
      if (dir_right !== d) begin miscompares++; $display("FAIL %s_dir: got %b want %b", name, dir_right, d); end
      n++;
    end
  endtask

  task automatic test_bounce_max;
    run_until(16'd600, "to_max");
    strobe(1'b0, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors += 2;
    if (gap_x !== 16'd600)  begin miscompares++; $display("FAIL bounce_max_hold: got %0d want 600", gap_x); end
    if (dir_right !== 1'b0) begin miscompares++; $display("FAIL bounce_max_dir: got %b want 0", dir_right); end
    strobe(1'b0, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors++;
    if (gap_x !== 16'd599)  begin miscompares++; $display("FAIL bounce_max_away: got %0d want 599", gap_x); end
    run_until(16'd100, "to_100");
  endtask

  // Load with stop=0 in LEFT at 100: load wins, direction kept.
  task automatic test_load;
    strobe(1'b0, 1'b1, 1'b0);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors += 2;
    if (gap_x !== 16'd320)  begin miscompares++; $display("FAIL load_gap: got %0d want 320", gap_x); end
    if (dir_right !== 1'b0) begin miscompares++; $display("FAIL load_dir: got %b want 0", dir_right); end
    strobe(1'b0, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors++;
    if (gap_x !== 16'd319)  begin miscompares++; $display("FAIL load_still_left: got %0d want 319", gap_x); end
  endtask

  task automatic test_bounce_min;
    run_until(16'd32, "to_min");
    strobe(1'b0, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors += 2;
    if (gap_x !== 16'd32)   begin miscompares++; $display("FAIL bounce_min_hold: got %0d want 32", gap_x); end
    if (dir_right !== 1'b1) begin miscompares++; $display("FAIL bounce_min_dir: got %b want 1", dir_right); end
    strobe(1'b0, 1'b0, 1'b1);
    void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
    vectors++;
    if (gap_x !== 16'd33)   begin miscompares++; $display("FAIL bounce_min_away: got %0d want 33", gap_x); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_state = 0; m_gap = START;
    @(negedge clk);
    strobe(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1);
    gexp_q.delete(); dexp_q.delete();
    vectors++;
    if (gap_x !== 16'd323) begin miscompares++; $display("FAIL premid_gap: got %0d want 323", gap_x); end
    wait_pixel(6, 200, ok);
    if (!ok) return;
    // px 199 is inside the left segment (ends at 323-16 = 307).
    vectors++;
    if (sha !== 1'b1) begin miscompares++; $display("FAIL premid_sha: got %b want 1", sha); end
    #5 reset_n = 1'b0;
    m_state = 0; m_gap = START;
    #1;
    vectors += 4;
    if (sha !== 1'b0)       begin miscompares++; $display("FAIL mid_reset_sha: got %b want 0", sha); end
    if (h_line !== 1'b0)    begin miscompares++; $display("FAIL mid_reset_h_line: got %b want 0", h_line); end
    if (gap_x !== 16'd320)  begin miscompares++; $display("FAIL mid_reset_gap: got %0d want 320", gap_x); end
    if (dir_right !== 1'b0) begin miscompares++; $display("FAIL mid_reset_dir: got %b want 0", dir_right); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b0, 1'b1);
      void'(gexp_q.pop_front()); void'(dexp_q.pop_front());
      vectors += 2;
      if (gap_x !== 16'd320)  begin miscompares++; $display("FAIL post_reset_gap: got %0d want 320", gap_x); end
      if (dir_right !== 1'b0) begin miscompares++; $display("FAIL post_reset_dir: got %b want 0", dir_right); end
    end
  endtask

  initial begin
    test_reset();
    test_row_scan();
    test_motion();
    test_freeze();
    test_bounce_max();
    test_load();
    test_bounce_min();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
